// File: rtl/acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_ctrl_pkg
// Description : Shared constants for the accumulation window controller:
//               default widths and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_ctrl_pkg;

    localparam int c_DEF_ACC_W = 16;
    localparam int c_DEF_WIN_W = 16;
    localparam int c_DEF_CNT_W = 8;

    // FSM state encoding
    localparam int c_ST_W = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/acc_result_hold.sv
`default_nettype none
// ============================================================================
// Module      : acc_result_hold
// Description : Single-entry valid/ready holding register for window counts,
//               with sticky overrun detection.
//   clk, reset_n      : clock, asynchronous active-low reset
//   i_load            : write i_data/i_idx into the register
//   i_data, i_idx     : window count and window index to store
//   i_ready           : downstream accepts when high with o_valid
//   i_clr_overrun     : clears the sticky overrun flag
//   o_valid, o_data,
//   o_idx, o_overrun  : register contents and status
// Revision    : 1.0 - initial release
// ============================================================================
module acc_result_hold #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_ready,
    input  logic              i_clr_overrun,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_overrun
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_idx;
    logic              r_overrun;

    // A result is lost only when a load lands on a full register that is
    // not being drained in the same cycle.
    logic w_lost;
    assign w_lost = i_load && r_valid && !i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
                r_idx   <= i_idx;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end else if (w_lost) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_idx     = r_idx;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/accumulation_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accumulation_window_ctrl
// Description : Sequencer for one bitstream accumulator. Gates the sources,
//               issues the accumulator dump pulse every window_len cycles and
//               captures each closed window's count into a holding register.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start, stop    : run request (IDLE only) / graceful stop (RUN only)
//   window_len     : cycles per window, latched on accepted start
//   num_windows    : windows to run, latched on accepted start, 0 = until stop
//   acc_out        : accumulator count
//   acc_enable     : accumulator dump/restart pulse
//   src_en         : bitstream source enable
//   result_*       : held window count, index, valid/ready handshake
//   busy, done     : activity flag / final-result pulse
//   overrun        : sticky lost-result flag
//   cfg_err        : pulse on start rejected for window_len == 0
// Revision    : 1.0 - initial release
// ============================================================================
module accumulation_window_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int ACC_DATA_WIDTH = c_DEF_ACC_W,
    parameter int WIN_W          = c_DEF_WIN_W,
    parameter int CNT_W          = c_DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic [WIN_W-1:0]          window_len,
    input  logic [CNT_W-1:0]          num_windows,
    input  logic [ACC_DATA_WIDTH-1:0] acc_out,
    output logic                      acc_enable,
    output logic                      src_en,
    output logic [ACC_DATA_WIDTH-1:0] result_data,
    output logic [CNT_W-1:0]          result_idx,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic                      cfg_err
);

    logic [c_ST_W-1:0] r_state;
    logic [WIN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_nwin;
    logic [WIN_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_win;
    logic              r_stop_pend;
    logic              r_cap_pend;
    logic [CNT_W-1:0]  r_cap_idx;
    logic              r_done;
    logic              r_cfg_err;

    logic              w_idle;
    logic              w_start_ok;
    logic              w_close;
    logic [CNT_W-1:0]  w_win_nxt;
    logic              w_last_win;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_start_ok = w_idle && start && (window_len != '0);
    assign w_close    = (r_state == c_ST_RUN) && (r_cyc == r_len);
    assign w_win_nxt  = r_win + CNT_W'(1);
    // A stop arriving in the closing cycle itself still makes that window
    // the last one. The nonzero check keeps num_windows == 0 free-running
    // even when the window counter wraps.
    assign w_last_win = ((r_nwin != '0) && (w_win_nxt == r_nwin))
                        || r_stop_pend || stop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_len       <= '0;
            r_nwin      <= '0;
            r_cyc       <= '0;
            r_win       <= '0;
            r_stop_pend <= 1'b0;
            r_cap_pend  <= 1'b0;
            r_cap_idx   <= '0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            // The accumulator presents the closed window's count in the
            // cycle after the dump pulse, so capture is deferred by one.
            r_cap_pend <= w_close;
            if (w_close) begin
                r_cap_idx <= r_win;
            end
            r_done    <= (r_state == c_ST_FLUSH);
            r_cfg_err <= w_idle && start && (window_len == '0);

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_ok) begin
                        r_len       <= window_len;
                        r_nwin      <= num_windows;
                        r_cyc       <= '0;
                        r_win       <= '0;
                        r_stop_pend <= 1'b0;
                        r_state     <= c_ST_PRIME;
                    end
                end
                c_ST_PRIME: begin
                    r_cyc   <= WIN_W'(1);
                    r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_close) begin
                        r_cyc <= WIN_W'(1);
                        r_win <= w_win_nxt;
                        if (w_last_win) begin
                            r_state <= c_ST_FLUSH;
                        end
                    end else begin
                        r_cyc <= r_cyc + WIN_W'(1);
                    end
                end
                c_ST_FLUSH: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // PRIME's pulse discards stale contents and opens window 0.
    assign acc_enable = (r_state == c_ST_PRIME) || w_close;
    assign src_en     = (r_state == c_ST_PRIME) || (r_state == c_ST_RUN);
    assign busy       = !w_idle;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;

    acc_result_hold #(
        .DATA_W (ACC_DATA_WIDTH),
        .IDX_W  (CNT_W)
    ) u_hold (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_load        (r_cap_pend),
        .i_data        (acc_out),
        .i_idx         (r_cap_idx),
        .i_ready       (result_ready),
        .i_clr_overrun (w_start_ok),
        .o_valid       (result_valid),
        .o_data        (result_data),
        .o_idx         (result_idx),
        .o_overrun     (overrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_accumulation_window_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_accumulation_window_ctrl
// Description : Self-checking bench for accumulation_window_ctrl. Expected
//               behaviour is computed per cycle from the window timing
//               arithmetic (E_k = T+1+(k+1)*L) and a simple hold-register
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulation_window_ctrl;

    localparam int AW = 16;
    localparam int WW = 16;
    localparam int CW = 8;
    localparam longint c_INF = 64'd1 << 40;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [CW-1:0] num_windows = '0;
    logic [AW-1:0] acc_out = '0;
    logic          result_ready = 1'b0;
    logic          acc_enable, src_en, result_valid, busy, done, overrun, cfg_err;
    logic [AW-1:0] result_data;
    logic [CW-1:0] result_idx;

    accumulation_window_ctrl #(
        .ACC_DATA_WIDTH (AW),
        .WIN_W          (WW),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .window_len   (window_len),
        .num_windows  (num_windows),
        .acc_out      (acc_out),
        .acc_enable   (acc_enable),
        .src_en       (src_en),
        .result_data  (result_data),
        .result_idx   (result_idx),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    longint        cyc = 0;
    bit            job = 1'b0;
    longint        t0 = 0;
    longint        L = 1;
    longint        last_k = 0;
    bit            m_valid = 1'b0;
    bit            m_ovr = 1'b0;
    bit            m_cfg = 1'b0;
    logic [AW-1:0] m_data = '0;
    logic [CW-1:0] m_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input bit s_start, input bit s_stop, input int s_len,
                        input int s_nw, input bit s_rdy, input logic [AW-1:0] s_acc);
        longint r, el, k;
        bit e_busy, e_src, e_en, e_done, load, idle;
        @(negedge clk);
        r  = cyc - t0;
        el = 1 + (last_k + 1) * L;
        e_busy = job && r >= 1 && r <= el + 1;
        e_src  = job && r >= 1 && r <= el;
        e_en   = job && (r == 1 || (r >= 1 + L && r <= el && (r - 1) % L == 0));
        e_done = job && r == el + 2;
        chk("busy", busy, e_busy);
        chk("src_en", src_en, e_src);
        chk("acc_enable", acc_enable, e_en);
        chk("done", done, e_done);
        chk("cfg_err", cfg_err, m_cfg);
        chk("result_valid", result_valid, m_valid);
        chk("result_data", result_data, m_data);
        chk("result_idx", result_idx, m_idx);
        chk("overrun", overrun, m_ovr);

        start        = s_start;
        stop         = s_stop;
        window_len   = s_len[WW-1:0];
        num_windows  = s_nw[CW-1:0];
        result_ready = s_rdy;
        acc_out      = s_acc;

        load = job && r >= 2 + L && r <= el + 1 && (r - 2) % L == 0;
        idle = !job || r >= el + 2;
        if (load) begin
            if (m_valid && !s_rdy) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = s_acc;
            m_idx   = CW'((r - 2) / L - 1);
        end else if (m_valid && s_rdy) begin
            m_valid = 1'b0;
        end
        // Stop in RUN makes the window in progress (first close at or after
        // this cycle) the last one.
        if (job && s_stop && r >= 2 && r <= el) begin
            k = (r - 1 + L - 1) / L - 1;
            if (k < last_k) last_k = k;
        end
        m_cfg = idle && s_start && s_len == 0;
        if (idle && s_start && s_len != 0) begin
            job    = 1'b1;
            t0     = cyc;
            L      = s_len;
            last_k = (s_nw == 0) ? c_INF : longint'(s_nw - 1);
            m_ovr  = 1'b0;
        end
        cyc++;
    endtask

    // rdy_mode: 0 = never ready, 1 = always ready, 2 = random.
    // poke: step index at which a stray start is issued (0 = none).
    task automatic run_job(input int len, input int nw, input int stop_at,
                           input int rdy_mode, input int ncyc, input int poke);
        bit rdy;
        step(1'b1, 1'b0, len, nw, rdy_mode != 0, AW'($urandom));
        for (int i = 1; i <= ncyc; i++) begin
            rdy = (rdy_mode == 2) ? bit'($urandom_range(1, 0)) : (rdy_mode == 1);
            step(i == poke, i == stop_at, (i == poke) ? len + 3 : len, nw, rdy, AW'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_acc_enable", acc_enable, 1'b0);
        chk("rst_src_en", src_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_data", result_data, '0);
        chk("rst_idx", result_idx, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        job     = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_cfg   = 1'b0;
        m_data  = '0;
        m_idx   = '0;
        cyc++;
    endtask

    initial begin
        int len, nw, sa, nc;
        do_reset();
        step(1'b0, 1'b0, 0, 0, 1'b1, '0);

        // Three windows of 4, always ready
        run_job(4, 3, 0, 1, 20, 0);
        // Window length 1: enable every cycle
        run_job(1, 2, 0, 1, 8, 0);
        // Free-running, stopped mid window 1
        run_job(8, 0, 10, 1, 25, 0);
        // Never ready: overrun, then cleared by the next start
        run_job(2, 3, 0, 0, 14, 0);
        run_job(3, 1, 0, 1, 10, 0);
        // Zero window length rejected
        step(1'b1, 1'b0, 0, 2, 1'b1, '0);
        step(1'b0, 1'b0, 0, 2, 1'b1, '0);
        step(1'b0, 1'b0, 0, 2, 1'b1, '0);
        // Stray start during RUN ignored
        run_job(5, 4, 0, 1, 30, 8);
        // Asynchronous reset in the middle of a free-running job
        run_job(4, 0, 0, 1, 7, 0);
        do_reset();
        run_job(4, 3, 0, 1, 20, 0);

        // Randomized jobs
        for (int j = 0; j < 14; j++) begin
            len = int'($urandom_range(6, 1));
            nw  = int'($urandom_range(5, 0));
            sa  = (nw == 0 || $urandom_range(3, 0) == 0) ? int'($urandom_range(30, 2)) : 0;
            nc  = 8 + ((nw != 0) ? nw * len : sa + len);
            run_job(len, nw, sa, 2, nc, (j % 4 == 1) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
